systolic_drain: RTL and testbench

- Receiver at the bottom edge of the systolic array. It takes the per-column psum outputs, which arrive skewed by one cycle per column.
- Deskews them into whole result rows and buffers the rows in a small FWFT FIFO.
- Presents one row per transfer on a valid/ready interface toward the unified-buffer writer.
- The array has no backpressure, so rows that arrive while the FIFO is full are dropped and flagged.

---
 rtl/systolic_drain.sv | 143 ++++++++++++++
 tb/tb_systolic_drain.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// Purpose: deskews per-column psums from the bottom edge of the array into whole rows and queues them in a FWFT FIFO.
// Latency: a row whose column 0 is valid in cycle t shows on out_valid/out_data in cycle t+WIDTH when the FIFO is empty.
// Backpressure: out_ready pops the head row; the array cannot stall, so a row arriving at a full FIFO with no pop is dropped and flagged.
module systolic_drain #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [31:0]       sys_data_in [WIDTH-1:0],
    input  logic [WIDTH-1:0]         sys_valid_in,
    input  logic [15:0]              col_size_in,
    input  logic                     col_size_valid_in,
    input  logic                     flush_in,
    output logic signed [31:0]       out_data [WIDTH-1:0],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow_err,
    output logic                     skew_err
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]   col_mask;
    logic [WIDTH-1:0]   mask_nxt;
    logic [WIDTH-1:0]   aln_vld;
    logic signed [31:0] aln_dat [WIDTH];
    logic signed [31:0] row_dat [WIDTH];
    logic               row_event;
    logic               skew_hit;
    logic               fifo_full;
    logic               rd_en;
    logic               wr_en;
    logic               drop;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic signed [31:0] mem [DEPTH][WIDTH];

    // Column j is delayed WIDTH-1-j cycles so every element of a row lines up with column 0.
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
        localparam int STAGES = WIDTH - 1 - j;
        if (STAGES == 0) begin : g_direct
            assign aln_vld[j] = sys_valid_in[j];
            assign aln_dat[j] = sys_data_in[j];
        end else begin : g_delay
            logic [STAGES-1:0]  vld_sr;
            logic signed [31:0] dat_sr [STAGES];

            // Shift register per column; flush only needs to kill the valids.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_sr <= '0;
                    for (int k = 0; k < STAGES; k++) dat_sr[k] <= '0;
                end else if (flush_in) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr[0] <= sys_valid_in[j];
                    dat_sr[0] <= sys_data_in[j];
                    for (int k = 1; k < STAGES; k++) begin
                        vld_sr[k] <= vld_sr[k-1];
                        dat_sr[k] <= dat_sr[k-1];
                    end
                end
            end

            assign aln_vld[j] = vld_sr[STAGES-1];
            assign aln_dat[j] = dat_sr[STAGES-1];
        end
    end

    // Mask bit i is set when column i is below the requested size; sizes >= WIDTH give all ones.
    always_comb begin
        mask_nxt = '0;
        for (int i = 0; i < WIDTH; i++) mask_nxt[i] = (32'(i) < 32'(col_size_in));
    end

    // Aligned row: column 0 defines the event, disabled columns read as zero, enabled ones must agree with column 0.
    always_comb begin
        row_event = aln_vld[0] && !flush_in;
        skew_hit  = |((aln_vld ^ {WIDTH{aln_vld[0]}}) & col_mask);
        for (int j = 0; j < WIDTH; j++) row_dat[j] = col_mask[j] ? aln_dat[j] : '0;
    end

    assign out_valid = (fifo_count != '0);
    assign fifo_full = (fifo_count == FULL_CNT);
    assign rd_en     = out_valid && out_ready;
    assign wr_en     = row_event && (!fifo_full || rd_en);
    assign drop      = row_event && fifo_full && !rd_en;

    // Column mask survives flush; only reset or a new size changes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   col_mask <= '1;
        else if (col_size_valid_in) col_mask <= mask_nxt;
    end

    // FIFO pointers and occupancy; a simultaneous write and read leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Row storage; contents are only meaningful under the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < WIDTH; j++) mem[wr_ptr][j] <= row_dat[j];
        end
    end

    // Head row falls through; gated to zero when empty so it reads 0 out of reset.
    always_comb begin
        for (int j = 0; j < WIDTH; j++) out_data[j] = out_valid ? mem[rd_ptr][j] : '0;
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_err <= 1'b0;
            skew_err     <= 1'b0;
        end else if (flush_in) begin
            overflow_err <= 1'b0;
            skew_err     <= 1'b0;
        end else begin
            if (drop)     overflow_err <= 1'b1;
            if (skew_hit) skew_err     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: randomized and directed rows checked against a cycle-level row model and a row scoreboard.
// Rows are launched on a per-cycle timeline; column j of a launch is driven j cycles later.
// The model decides which rows reach the FIFO; the monitor compares every presented head row.
module tb_systolic_drain;
    localparam int W  = 4;
    localparam int D  = 2;
    localparam int HN = 4096;

    typedef logic [W*32-1:0] prow_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [31:0] sys_data_in [W-1:0];
    logic [W-1:0]       sys_valid_in;
    logic [15:0]        col_size_in;
    logic               col_size_valid_in;
    logic               flush_in;
    logic signed [31:0] out_data [W-1:0];
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         fifo_count;
    logic               overflow_err;
    logic               skew_err;

    systolic_drain #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst_n),
        .sys_data_in(sys_data_in), .sys_valid_in(sys_valid_in),
        .col_size_in(col_size_in), .col_size_valid_in(col_size_valid_in),
        .flush_in(flush_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .overflow_err(overflow_err), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    // launch timeline
    bit                 hv  [HN];
    logic [W-1:0]       hom [HN];
    logic signed [31:0] hd  [HN][W];
    int                 cyc;
    int                 last_clr;

    // reference model state
    int                 m_cnt;
    bit                 m_ovf;
    bit                 m_skw;
    logic [W-1:0]       m_mask;
    prow_t              exp_q [$];

    int                 n_cmp = 0;
    int                 n_bad = 0;
    bit                 mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_status();
        chk("out_valid", int'(out_valid), int'(m_cnt > 0));
        chk("fifo_count", int'(fifo_count), m_cnt);
        chk("overflow_err", int'(overflow_err), int'(m_ovf));
        chk("skew_err", int'(skew_err), int'(m_skw));
    endtask

    task automatic check_zero_outputs(input string tag);
        prow_t act;
        for (int j = 0; j < W; j++) act[j*32 +: 32] = out_data[j];
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_fifo_count"}, int'(fifo_count), 0);
        chk({tag, "_overflow_err"}, int'(overflow_err), 0);
        chk({tag, "_skew_err"}, int'(skew_err), 0);
        n_cmp++;
        if (act !== '0) begin
            n_bad++;
            $display("FAIL %s_out_data: got %h, expected 0", tag, act);
        end
    endtask

    // Model of one cycle, from the row rules: a launch at L is aligned at L+W-1;
    // an element survives only if it entered after the last flush/reset.
    task automatic model_step();
        bit    cv [W];
        bit    ev;
        bit    pop;
        int    l;
        int    sh;
        prow_t row;
        if (flush_in) begin
            m_cnt = 0;
            exp_q.delete();
            m_ovf = 1'b0;
            m_skw = 1'b0;
            last_clr = cyc;
        end else begin
            l = cyc - (W - 1);
            for (int j = 0; j < W; j++)
                cv[j] = (l >= 0) && hv[l] && !hom[l][j] && (l + j > last_clr);
            ev = cv[0];
            for (int j = 0; j < W; j++)
                if (m_mask[j] && (cv[j] != ev)) m_skw = 1'b1;
            pop = (m_cnt > 0) && out_ready;
            if (ev) begin
                if (m_cnt < D || pop) begin
                    for (int j = 0; j < W; j++)
                        row[j*32 +: 32] = m_mask[j] ? hd[l][j] : 32'sd0;
                    exp_q.push_back(row);
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (pop) m_cnt--;
        end
        if (col_size_valid_in) begin
            if (col_size_in >= 16'(W)) begin
                m_mask = '1;
            end else begin
                sh = 1 << col_size_in;
                m_mask = W'(sh - 1);
            end
        end
    endtask

    // One clock cycle: record the launch, drive skewed columns, check, advance the model.
    task automatic step(input bit lv, input logic [W-1:0] om, input bit rdy,
                        input bit fl, input bit csv, input logic [15:0] cs,
                        input int base, input int inc);
        hv[cyc]  = lv;
        hom[cyc] = om;
        for (int j = 0; j < W; j++) hd[cyc][j] = (base < 0) ? $urandom : base + inc * j;
        for (int j = 0; j < W; j++) begin
            int l;
            l = cyc - j;
            if (l >= 0 && hv[l]) begin
                sys_valid_in[j] = !hom[l][j];
                sys_data_in[j]  = hd[l][j];
            end else begin
                sys_valid_in[j] = 1'b0;
                sys_data_in[j]  = $urandom;
            end
        end
        out_ready         = rdy;
        flush_in          = fl;
        col_size_valid_in = csv;
        col_size_in       = cs;
        @(negedge clk);
        check_status();
        #1 model_step();
        @(posedge clk);
        #1 cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0, 1'b0, 16'd0, -1, 0);
    endtask

    // Asynchronous reset in the middle of a cycle; launches in flight are abandoned.
    task automatic do_reset();
        for (int k = cyc - W; k <= cyc; k++) if (k >= 0) hv[k] = 1'b0;
        sys_valid_in      = '0;
        flush_in          = 1'b0;
        col_size_valid_in = 1'b0;
        out_ready         = 1'b0;
        #2 rst_n = 1'b0;
        mon_en = 1'b0;
        #1 check_zero_outputs("async_reset");
        m_cnt = 0;
        exp_q.delete();
        m_ovf  = 1'b0;
        m_skw  = 1'b0;
        m_mask = '1;
        @(posedge clk);
        #1 cyc++;
        hv[cyc] = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        last_clr = cyc;
        mon_en   = 1'b1;
        @(posedge clk);
        #1 cyc++;
    endtask

    // Scoreboard monitor: every presented head row must match the oldest expected row.
    always @(negedge clk) begin
        prow_t act;
        if (mon_en && out_valid) begin
            for (int j = 0; j < W; j++) act[j*32 +: 32] = out_data[j];
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_row (cycle %0d): got %h, expected no row", cyc, act);
            end else begin
                if (act !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL out_row (cycle %0d): got %h, expected %h", cyc, act, exp_q[0]);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int           r;
        bit           lv;
        logic [W-1:0] om;
        rst_n             = 1'b0;
        sys_valid_in      = '0;
        for (int j = 0; j < W; j++) sys_data_in[j] = '0;
        col_size_in       = '0;
        col_size_valid_in = 1'b0;
        flush_in          = 1'b0;
        out_ready         = 1'b0;
        m_cnt = 0; m_ovf = 1'b0; m_skw = 1'b0; m_mask = '1;
        cyc = 0; last_clr = -1;
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1 cyc = 0;

        // single skewed row, data 100+j, then pop
        idle(2, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 16'd0, 100, 1);
        idle(5, 1'b0);
        idle(2, 1'b1);

        // three back-to-back rows into a 2-deep FIFO with no reader: third dropped
        for (int i = 0; i < 12; i++)
            step(i < 3, '0, i >= 8, 1'b0, 1'b0, 16'd0, (i < 3) ? 10 * i : -1, 1);

        // clear flags, then the third row arrives while the full FIFO is being read
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 16'd0, -1, 0);
        for (int i = 0; i < 10; i++)
            step(i < 3, '0, i >= 5, 1'b0, 1'b0, 16'd0, (i < 3) ? 10 * i : -1, 1);

        // two active columns: masked data, omitted masked column, omitted active column
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 16'd2, -1, 0);
        step(1'b1, '0, 1'b1, 1'b0, 1'b0, 16'd0, 7, 0);
        idle(5, 1'b1);
        step(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 16'd0, 7, 0);
        idle(5, 1'b1);
        step(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 16'd0, 7, 0);
        idle(5, 1'b1);

        // reset with one row stored and another in flight; nothing may appear afterwards
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 16'd0, -1, 0);
        idle(5, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 16'd0, -1, 0);
        idle(1, 1'b0);
        do_reset();
        idle(10, 1'b1);

        // FIFO full with both flags set, flush, then a row proves the mask was kept
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'd2, -1, 0);
        for (int i = 0; i < 4; i++)
            step(1'b1, (i == 3) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0, -1, 0);
        idle(5, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 16'd0, -1, 0);
        step(1'b1, '0, 1'b1, 1'b0, 1'b0, 16'd0, 5, 1);
        idle(6, 1'b1);

        // randomized traffic with occasional flush, resize and reset
        for (int i = 0; i < 2000; i++) begin
            r  = $urandom_range(0, 99);
            lv = ($urandom_range(0, 2) != 0);
            om = ($urandom_range(0, 15) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
            if (r == 0)
                do_reset();
            else
                step(lv, om, $urandom_range(0, 3) != 0, r == 1, (r == 2) || (r == 3),
                     16'($urandom_range(0, 6)), -1, 0);
        end

        idle(8, 1'b1);
        chk("drain_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
